// File: rtl/rast_pkg.sv
// Shared rasterizer types: sequencer states, vertex/box layouts and the
// subsample step helper.
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    typedef logic signed [SIGFIG-1:0] coord_t;
    typedef coord_t [AXIS-1:0]        vertex_t;
    typedef vertex_t [VERTS-1:0]      tri_t;
    typedef coord_t [1:0]             point_t;
    typedef point_t [1:0]             box_t;

    function automatic logic [1:0] clamp_lg2(input logic [3:0] lg2);
        return (lg2 > 4'd3) ? 2'd3 : lg2[1:0];
    endfunction

    // Distance between subsample locations in fixed point; lg2 above 3 acts as 3.
    function automatic coord_t step_from_lg2(input logic [3:0] lg2);
        logic [4:0] sh;
        sh = 5'(RADIX) - {3'b000, clamp_lg2(lg2)};
        return coord_t'(1) << sh;
    endfunction

endpackage

// File: rtl/sample_sequencer.sv
// Walks each triangle's bounding box on the subsample grid in raster order,
// emitting one sample location per cycle to the sample-test stage.
module sample_sequencer
    import rast_pkg::*;
#(
    parameter int SIGFIG = rast_pkg::SIGFIG,
    parameter int RADIX  = rast_pkg::RADIX,
    parameter int VERTS  = rast_pkg::VERTS,
    parameter int AXIS   = rast_pkg::AXIS,
    parameter int COLORS = rast_pkg::COLORS
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R13S,
    input  logic                                           validTri_R13H,
    input  logic        [3:0]                              ss_w_lg2_R13S,
    output logic                                           halt_RnnnnL,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                  sample_R14S,
    output logic                                           validSamp_R14H
);

    state_t state_q, state_d;

    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;

    logic signed [SIGFIG-1:0] step_q, step_d;
    logic signed [SIGFIG-1:0] llx_q, llx_d;
    logic signed [SIGFIG-1:0] urx_q, urx_d;
    logic signed [SIGFIG-1:0] ury_q, ury_d;
    logic signed [SIGFIG-1:0] x_q, x_d;
    logic signed [SIGFIG-1:0] y_q, y_d;

    logic signed [SIGFIG-1:0] new_step;
    logic signed [SIGFIG-1:0] grid_mask;
    logic signed [SIGFIG-1:0] n_llx, n_lly, n_urx, n_ury;
    logic signed [SIGFIG:0]   x_nxt, y_nxt;
    logic                     x_fits, y_over, last, degen, accept;

    always_comb begin
        new_step  = SIGFIG'(step_from_lg2(ss_w_lg2_R13S));
        grid_mask = ~(new_step - SIGFIG'(1));
        n_llx     = box_R13S[0][0] & grid_mask;
        n_lly     = box_R13S[0][1] & grid_mask;
        n_urx     = box_R13S[1][0] & grid_mask;
        n_ury     = box_R13S[1][1] & grid_mask;
        degen     = (n_urx < n_llx) || (n_ury < n_lly);

        // One extra bit so stepping past the positive limit cannot wrap.
        x_nxt  = {x_q[SIGFIG-1], x_q} + {step_q[SIGFIG-1], step_q};
        y_nxt  = {y_q[SIGFIG-1], y_q} + {step_q[SIGFIG-1], step_q};
        x_fits = x_nxt <= {urx_q[SIGFIG-1], urx_q};
        y_over = y_nxt > {ury_q[SIGFIG-1], ury_q};
        last   = (state_q == TEST) && !x_fits && y_over;

        halt_RnnnnL = (state_q == WAIT) || last;
        accept      = validTri_R13H && halt_RnnnnL;

        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        step_d  = step_q;
        llx_d   = llx_q;
        urx_d   = urx_q;
        ury_d   = ury_q;
        x_d     = x_q;
        y_d     = y_q;

        if (accept) begin
            tri_d   = tri_R13S;
            color_d = color_R13U;
            step_d  = new_step;
            llx_d   = n_llx;
            urx_d   = n_urx;
            ury_d   = n_ury;
            x_d     = n_llx;
            y_d     = n_lly;
            state_d = degen ? WAIT : TEST;
        end else if (state_q == TEST) begin
            if (last) begin
                state_d = WAIT;
            end else if (x_fits) begin
                x_d = x_nxt[SIGFIG-1:0];
            end else begin
                x_d = llx_q;
                y_d = y_nxt[SIGFIG-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            tri_q   <= '0;
            color_q <= '0;
            step_q  <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            step_q  <= step_d;
            llx_q   <= llx_d;
            urx_q   <= urx_d;
            ury_q   <= ury_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = x_q;
    assign sample_R14S[1] = y_q;
    assign validSamp_R14H = (state_q == TEST);

endmodule
